// File: rtl/gray_pkg.sv
// Shared mode encoding and Gray/binary helpers for the Gray-code pipeline.
// Helpers work on a MAX_WIDTH zero-extended vector; callers cast back to their width.
package gray_pkg;

  localparam int unsigned MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    MODE_BIN2GRAY = 2'b00,
    MODE_GRAY2BIN = 2'b01,
    MODE_GRAY_INC = 2'b10,
    MODE_GRAY_DEC = 2'b11
  } mode_e;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the result unaffected.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b = g;
    for (int unsigned i = 1; i < MAX_WIDTH; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_pipe_slice.sv
// One elastic valid/ready register slice carrying data, mode and wrap flag.
module gray_pipe_slice
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  mode_e            in_mode,
  input  logic             in_wrap,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output mode_e            out_mode,
  output logic             out_wrap
);

  // Loads whenever empty or draining this cycle, so a full pipe streams without bubbles.
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= MODE_BIN2GRAY;
      out_wrap  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_mode <= in_mode;
        out_wrap <= in_wrap;
      end
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Two-stage pipelined Gray-code engine: S1 holds the binary operand, S2 holds the result.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic             out_wrap
);

  mode_e            in_mode_e;
  logic [WIDTH-1:0] in_bin;
  logic             in_wrap;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_bin;
  mode_e            s1_mode;
  logic             s1_wrap;
  logic             s2_ready;
  mode_e            s2_mode;

  logic [WIDTH-1:0] bin_inc;
  logic [WIDTH-1:0] bin_dec;
  logic [WIDTH-1:0] result;

  assign in_mode_e = mode_e'(in_mode);

  // Wrap depends only on the binary operand, so it is resolved here and carried through S1.
  always_comb begin
    in_bin  = (in_mode_e == MODE_BIN2GRAY) ? in_data
                                           : WIDTH'(gray2bin(MAX_WIDTH'(in_data)));
    in_wrap = ((in_mode_e == MODE_GRAY_INC) && (in_bin == '1)) ||
              ((in_mode_e == MODE_GRAY_DEC) && (in_bin == '0));
  end

  gray_pipe_slice #(.WIDTH(WIDTH)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bin),
    .in_mode   (in_mode_e),
    .in_wrap   (in_wrap),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_bin),
    .out_mode  (s1_mode),
    .out_wrap  (s1_wrap)
  );

  always_comb begin
    bin_inc = s1_bin + WIDTH'(1);
    bin_dec = s1_bin - WIDTH'(1);
    result  = s1_bin;
    case (s1_mode)
      MODE_BIN2GRAY: result = WIDTH'(bin2gray(MAX_WIDTH'(s1_bin)));
      MODE_GRAY2BIN: result = s1_bin;
      MODE_GRAY_INC: result = WIDTH'(bin2gray(MAX_WIDTH'(bin_inc)));
      MODE_GRAY_DEC: result = WIDTH'(bin2gray(MAX_WIDTH'(bin_dec)));
    endcase
  end

  gray_pipe_slice #(.WIDTH(WIDTH)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (result),
    .in_mode   (s1_mode),
    .in_wrap   (s1_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (s2_mode),
    .out_wrap  (out_wrap)
  );

  assign out_mode = s2_mode;

endmodule
